// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: evaluates conditional branches, CALL and RET,
// maintains a circular return-address stack and drives the post-redirect squash window.
module branch_resolve_unit #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned SHADOW    = 2,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [2:0]        br_op,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic [DATA_W-1:0] rs1_val,
  input  logic [DATA_W-1:0] rs2_val,
  output logic              branch_taken,
  output logic [ADDR_W-1:0] w_instruction_address,
  output logic              link_valid,
  output logic [ADDR_W-1:0] link_addr,
  output logic              squash,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam int unsigned SP_W  = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = SP_W + 1;
  localparam int unsigned SQ_W  = (SHADOW > 0) ? $clog2(SHADOW + 1) : 1;

  typedef enum logic [2:0] {
    OpBeq  = 3'b000,
    OpBne  = 3'b001,
    OpBlt  = 3'b010,
    OpBge  = 3'b011,
    OpBltu = 3'b100,
    OpBgeu = 3'b101,
    OpCall = 3'b110,
    OpRet  = 3'b111
  } br_op_e;

  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic [CNT_W-1:0]  count_q;
  logic [SQ_W-1:0]   shadow_q;

  br_op_e            op;
  logic              accept;
  logic              cond_taken;
  logic              is_call;
  logic              is_ret;
  logic              taken;
  logic              ras_empty;
  logic              ras_full;
  logic [SP_W-1:0]   sp_dec;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] return_addr;
  logic [ADDR_W-1:0] target;

  assign op        = br_op_e'(br_op);
  assign squash    = (shadow_q != '0);
  assign accept    = br_valid & ~squash;
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == CNT_W'(RAS_DEPTH));
  assign sp_dec    = sp_q - SP_W'(1);

  // Address arithmetic is modulo 2^ADDR_W; carries are intentionally dropped.
  assign branch_target = br_pc + br_offset;
  assign return_addr   = br_pc + ADDR_W'(1);

  always_comb begin
    cond_taken = 1'b0;
    is_call    = 1'b0;
    is_ret     = 1'b0;
    unique case (op)
      OpBeq:  cond_taken = (rs1_val == rs2_val);
      OpBne:  cond_taken = (rs1_val != rs2_val);
      OpBlt:  cond_taken = ($signed(rs1_val) <  $signed(rs2_val));
      OpBge:  cond_taken = ($signed(rs1_val) >= $signed(rs2_val));
      OpBltu: cond_taken = (rs1_val <  rs2_val);
      OpBgeu: cond_taken = (rs1_val >= rs2_val);
      OpCall: is_call    = 1'b1;
      OpRet:  is_ret     = 1'b1;
    endcase
  end

  always_comb begin
    taken  = cond_taken | is_call | is_ret;
    target = branch_target;
    if (is_ret) begin
      // An empty stack falls back to the register-supplied return target.
      target = ras_empty ? ADDR_W'(rs1_val) : stack_q[sp_dec];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_taken          <= 1'b0;
      w_instruction_address <= '0;
      link_valid            <= 1'b0;
      link_addr             <= '0;
      ras_overflow          <= 1'b0;
      ras_underflow         <= 1'b0;
      sp_q                  <= '0;
      count_q               <= '0;
      shadow_q              <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      branch_taken  <= accept & taken;
      link_valid    <= accept & is_call;
      ras_overflow  <= accept & is_call & ras_full;
      ras_underflow <= accept & is_ret & ras_empty;

      if (accept && taken) begin
        w_instruction_address <= target;
      end

      if (accept && is_call) begin
        link_addr     <= return_addr;
        stack_q[sp_q] <= return_addr;
        sp_q          <= sp_q + SP_W'(1);
        if (!ras_full) begin
          count_q <= count_q + CNT_W'(1);
        end
      end else if (accept && is_ret && !ras_empty) begin
        sp_q    <= sp_dec;
        count_q <= count_q - CNT_W'(1);
      end

      if (accept && taken) begin
        shadow_q <= SQ_W'(SHADOW);
      end else if (shadow_q != '0) begin
        shadow_q <= shadow_q - SQ_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic [2:0]  br_op;
  logic [15:0] br_pc;
  logic [15:0] br_offset;
  logic [15:0] rs1_val;
  logic [15:0] rs2_val;
  logic        branch_taken;
  logic [15:0] w_instruction_address;
  logic        link_valid;
  logic [15:0] link_addr;
  logic        squash;
  logic        ras_overflow;
  logic        ras_underflow;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, BLT = 3'b010, BGE = 3'b011;
  localparam logic [2:0] BLTU = 3'b100, BGEU = 3'b101, CALL = 3'b110, RET = 3'b111;

  branch_resolve_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .SHADOW   (2),
    .RAS_DEPTH(4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .br_valid             (br_valid),
    .br_op                (br_op),
    .br_pc                (br_pc),
    .br_offset            (br_offset),
    .rs1_val              (rs1_val),
    .rs2_val              (rs2_val),
    .branch_taken         (branch_taken),
    .w_instruction_address(w_instruction_address),
    .link_valid           (link_valid),
    .link_addr            (link_addr),
    .squash               (squash),
    .ras_overflow         (ras_overflow),
    .ras_underflow        (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present one instruction for a single edge, then sample 1ns after it.
  task automatic issue(input logic [2:0] op, input logic [15:0] pc, input logic [15:0] off,
                       input logic [15:0] a, input logic [15:0] b);
    br_valid  = 1'b1;
    br_op     = op;
    br_pc     = pc;
    br_offset = off;
    rs1_val   = a;
    rs2_val   = b;
    @(posedge clk);
    #1;
    br_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    br_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".taken"}, 32'(branch_taken), 32'd0);
    check({tag, ".link"},  32'(link_valid),   32'd0);
    check({tag, ".squash"}, 32'(squash),      32'd0);
    check({tag, ".ovf"},   32'(ras_overflow), 32'd0);
    check({tag, ".udf"},   32'(ras_underflow), 32'd0);
  endtask

  logic [15:0] call_pcs [5];
  logic [15:0] ret_exp  [5];

  initial begin
    call_pcs = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050};
    ret_exp  = '{16'h0051, 16'h0041, 16'h0031, 16'h0021, 16'h0ABC};
    reset = 1'b1;
    br_valid = 1'b0; br_op = '0; br_pc = '0; br_offset = '0; rs1_val = '0; rs2_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    check("reset.addr", 32'(w_instruction_address), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // BEQ taken, then two BEQs in the shadow must be ignored.
    issue(BEQ, 16'h0010, 16'h0004, 16'h0005, 16'h0005);
    check("beq.taken", 32'(branch_taken), 32'd1);
    check("beq.addr", 32'(w_instruction_address), 32'h0014);
    check("beq.squash1", 32'(squash), 32'd1);
    issue(BEQ, 16'h0040, 16'h0004, 16'h0001, 16'h0001);
    check("shadow1.taken", 32'(branch_taken), 32'd0);
    check("beq.squash2", 32'(squash), 32'd1);
    issue(BEQ, 16'h0050, 16'h0004, 16'h0001, 16'h0001);
    check("shadow2.taken", 32'(branch_taken), 32'd0);
    check("beq.squash_end", 32'(squash), 32'd0);
    idle(1);
    check("shadow.nothing", 32'(branch_taken), 32'd0);

    // Signed vs unsigned compare on 0xFFFF / 0x0001.
    issue(BLT, 16'h0200, 16'h0010, 16'hFFFF, 16'h0001);
    check("blt.taken", 32'(branch_taken), 32'd1);
    check("blt.addr", 32'(w_instruction_address), 32'h0210);
    idle(2);
    issue(BLTU, 16'h0200, 16'h0010, 16'hFFFF, 16'h0001);
    check_quiet("bltu");
    issue(BGE, 16'h0300, 16'h0008, 16'hFFFF, 16'h0001);
    check("bge.taken", 32'(branch_taken), 32'd0);
    issue(BGEU, 16'h0300, 16'h0008, 16'hFFFF, 16'h0001);
    check("bgeu.taken", 32'(branch_taken), 32'd1);
    check("bgeu.addr", 32'(w_instruction_address), 32'h0308);
    idle(2);
    issue(BNE, 16'h0300, 16'h0008, 16'h0007, 16'h0007);
    check("bne_eq.taken", 32'(branch_taken), 32'd0);

    // CALL then RET.
    issue(CALL, 16'h0100, 16'h0020, 16'h0000, 16'h0000);
    check("call.taken", 32'(branch_taken), 32'd1);
    check("call.addr", 32'(w_instruction_address), 32'h0120);
    check("call.link_valid", 32'(link_valid), 32'd1);
    check("call.link_addr", 32'(link_addr), 32'h0101);
    check("call.ovf", 32'(ras_overflow), 32'd0);
    idle(1);
    check("call.link_pulse", 32'(link_valid), 32'd0);
    idle(1);
    issue(RET, 16'h0130, 16'h0000, 16'h0000, 16'h0000);
    check("ret.taken", 32'(branch_taken), 32'd1);
    check("ret.addr", 32'(w_instruction_address), 32'h0101);
    check("ret.udf", 32'(ras_underflow), 32'd0);
    idle(2);

    // Five CALLs overflow a 4-deep stack; five RETs drain it and underflow.
    for (int i = 0; i < 5; i++) begin
      issue(CALL, call_pcs[i], 16'h0000, 16'h0000, 16'h0000);
      check($sformatf("callx%0d.ovf", i), 32'(ras_overflow), (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("callx%0d.link", i), 32'(link_addr), 32'(call_pcs[i] + 16'h1));
      idle(2);
    end
    for (int i = 0; i < 5; i++) begin
      issue(RET, 16'h0600, 16'h0000, 16'h0ABC, 16'h0000);
      check($sformatf("retx%0d.taken", i), 32'(branch_taken), 32'd1);
      check($sformatf("retx%0d.addr", i), 32'(w_instruction_address), 32'(ret_exp[i]));
      check($sformatf("retx%0d.udf", i), 32'(ras_underflow), (i == 4) ? 32'd1 : 32'd0);
      idle(2);
    end

    // Target wraps modulo 2^16.
    issue(BNE, 16'hFFFE, 16'h0003, 16'h0001, 16'h0002);
    check("wrap.taken", 32'(branch_taken), 32'd1);
    check("wrap.addr", 32'(w_instruction_address), 32'h0001);
    idle(2);

    // Reset right after an accepted taken BEQ; RAS was non-empty before.
    issue(CALL, 16'h0700, 16'h0010, 16'h0000, 16'h0000);
    idle(2);
    issue(BEQ, 16'h0800, 16'h0010, 16'h0003, 16'h0003);
    check("prerst.taken", 32'(branch_taken), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_quiet("rst_async");
    check("rst_async.addr", 32'(w_instruction_address), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_quiet("postrst");
    issue(RET, 16'h0900, 16'h0000, 16'h0777, 16'h0000);
    check("postrst.ret_addr", 32'(w_instruction_address), 32'h0777);
    check("postrst.udf", 32'(ras_underflow), 32'd1);
    idle(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
